// File: rtl/work_packet_tx.sv
// Packet UART transmitter: sends a fixed-length payload as a train of 8N1/8N2 bytes.
// Supports start/abort control, byte-order selection and a completed-byte count.
module work_packet_tx #(
  parameter int comm_clk_frequency = 100_000_000,
  parameter int baud_rate          = 115_200,
  parameter int PAYLOAD_BYTES      = 84,
  parameter int STOP_BITS          = 1,
  parameter int MSB_BYTE_FIRST     = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [PAYLOAD_BYTES*8-1:0] data,
  input  logic                       start,
  input  logic                       abort,
  output logic                       TxD,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 bytes_sent
);

  localparam int DIV  = comm_clk_frequency / baud_rate;
  localparam int SDIV = DIV * STOP_BITS;
  localparam int CW   = (SDIV > 1) ? $clog2(SDIV) : 1;
  localparam int W    = PAYLOAD_BYTES * 8;

  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_END = CW'(SDIV - 1);
  localparam logic [7:0]    LAST     = 8'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    left;
  logic [W-1:0]  shreg;
  logic [W-1:0]  load;
  logic          cut;
  logic          quit;
  logic          bit_end;
  logic          stop_end;

  assign bit_end  = (cnt == BIT_END);
  assign stop_end = (cnt == STOP_END);

  // Byte order is fixed at load time so the shifter always emits bit 0 next.
  for (genvar i = 0; i < PAYLOAD_BYTES; i++) begin : g_ord
    if (MSB_BYTE_FIRST != 0) begin : g_rev
      assign load[i*8 +: 8] = data[(PAYLOAD_BYTES-1-i)*8 +: 8];
    end else begin : g_fwd
      assign load[i*8 +: 8] = data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      left       <= '0;
      shreg      <= '0;
      cut        <= 1'b0;
      quit       <= 1'b0;
      TxD        <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      bytes_sent <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= START;
            shreg      <= load;
            cnt        <= '0;
            bit_idx    <= '0;
            left       <= LAST;
            cut        <= 1'b0;
            quit       <= 1'b0;
            TxD        <= 1'b0;
            busy       <= 1'b1;
            bytes_sent <= '0;
          end
        end
        START: begin
          if (abort) begin
            state   <= STOP;
            cnt     <= '0;
            bit_idx <= '0;
            cut     <= 1'b1;
            quit    <= 1'b1;
            TxD     <= 1'b1;
          end else if (bit_end) begin
            state <= DATA;
            cnt   <= '0;
            TxD   <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (abort) begin
            state   <= STOP;
            cnt     <= '0;
            bit_idx <= '0;
            cut     <= 1'b1;
            quit    <= 1'b1;
            TxD     <= 1'b1;
          end else if (bit_end) begin
            cnt   <= '0;
            shreg <= {1'b0, shreg[W-1:1]};
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= '0;
              TxD     <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TxD     <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (stop_end) begin
            cnt <= '0;
            if (!cut) begin
              bytes_sent <= bytes_sent + 8'd1;
            end
            // An abort seen here still lets this stop period finish.
            if (quit || abort || (left == 8'd0)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= !(quit || abort);
            end else begin
              state <= START;
              left  <= left - 8'd1;
              TxD   <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (abort) begin
              quit <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          TxD   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_work_packet_tx.sv
// Bench for work_packet_tx: UART receiver feeding a byte scoreboard,
// plus timing, abort, re-start and reset checks on three configurations.
module tb_work_packet_tx;

  localparam int DIV = 1_000_000 / 115_200;

  logic         clk;
  logic         reset_n;
  logic         abort;
  logic         start_a, start_b, start_c;
  logic [15:0]  data_a, data_b;
  logic [671:0] data_c;
  logic         tx_a, tx_b, tx_c;
  logic         busy_a, busy_b, busy_c;
  logic         done_a, done_b, done_c;
  logic [7:0]   bs_a, bs_b, bs_c;

  logic         tx_s, busy_s, done_s;
  logic [7:0]   bsent_s;
  int           sel = 0;

  int n_vec = 0;
  int n_bad = 0;
  int busy_cyc = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  work_packet_tx #(
    .comm_clk_frequency(1_000_000), .baud_rate(115_200),
    .PAYLOAD_BYTES(2), .STOP_BITS(1), .MSB_BYTE_FIRST(0)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .data(data_a),
    .start(start_a), .abort(abort), .TxD(tx_a),
    .busy(busy_a), .done(done_a), .bytes_sent(bs_a)
  );

  work_packet_tx #(
    .comm_clk_frequency(1_000_000), .baud_rate(115_200),
    .PAYLOAD_BYTES(2), .STOP_BITS(1), .MSB_BYTE_FIRST(1)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .data(data_b),
    .start(start_b), .abort(abort), .TxD(tx_b),
    .busy(busy_b), .done(done_b), .bytes_sent(bs_b)
  );

  work_packet_tx #(
    .comm_clk_frequency(1_000_000), .baud_rate(115_200),
    .PAYLOAD_BYTES(84), .STOP_BITS(2), .MSB_BYTE_FIRST(0)
  ) u_c (
    .clk(clk), .reset_n(reset_n), .data(data_c),
    .start(start_c), .abort(abort), .TxD(tx_c),
    .busy(busy_c), .done(done_c), .bytes_sent(bs_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    tx_s    = tx_a;
    busy_s  = busy_a;
    done_s  = done_a;
    bsent_s = bs_a;
    case (sel)
      1: begin
        tx_s = tx_b; busy_s = busy_b;
        done_s = done_b; bsent_s = bs_b;
      end
      2: begin
        tx_s = tx_c; busy_s = busy_c;
        done_s = done_c; bsent_s = bs_c;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (busy_s) busy_cyc++;
      if (done_s) done_cnt++;
    end
  end

  // Mid-bit sampling receiver on the selected line.
  initial begin
    int cnt;
    int k;
    bit act;
    logic [7:0] sh;
    logic [7:0] e;
    act = 1'b0; cnt = 0; sh = '0;
    forever begin
      @(negedge clk);
      if (!busy_s) begin
        act = 1'b0;
      end else if (!act) begin
        if (!tx_s) begin
          act = 1'b1;
          cnt = 1;
        end
      end else begin
        cnt++;
        if (cnt % DIV == DIV / 2) begin
          k = cnt / DIV;
          if (k == 0) begin
            if (tx_s) act = 1'b0;
          end else if (k <= 8) begin
            sh = {tx_s, sh[7:1]};
          end else begin
            chk("rx_stop", 32'(tx_s), 32'd1);
            chk("rx_pend", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("rx_byte", 32'(sh), 32'(e));
            end
            act = 1'b0;
          end
        end
      end
    end
  end

  task automatic kick(input int s, input bit ab);
    busy_cyc = 0;
    done_cnt = 0;
    case (s)
      0: begin
        exp_q.push_back(data_a[7:0]);
        exp_q.push_back(data_a[15:8]);
        start_a = 1'b1;
      end
      1: begin
        exp_q.push_back(data_b[15:8]);
        exp_q.push_back(data_b[7:0]);
        start_b = 1'b1;
      end
      default: begin
        for (int i = 0; i < 84; i++)
          exp_q.push_back(data_c[i*8 +: 8]);
        start_c = 1'b1;
      end
    endcase
    abort = ab;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    abort   = 1'b0;
    chk("lat_tx", 32'(tx_s), 32'd0);
    chk("lat_busy", 32'(busy_s), 32'd1);
    chk("lat_bsent", 32'(bsent_s), 32'd0);
  endtask

  task automatic wait_end(input string tag, input int cyc,
                          input bit d, input int nb);
    int t = 0;
    while (busy_s && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_at_end"}, 32'(done_s), 32'(d));
    @(negedge clk);
    chk({tag, "_done_after"}, 32'(done_s), 32'd0);
    chk({tag, "_busy_cyc"}, 32'(busy_cyc), 32'(cyc));
    chk({tag, "_ndone"}, 32'(done_cnt), 32'(d));
    chk({tag, "_bsent"}, 32'(bsent_s), 32'(nb));
    chk({tag, "_idle_tx"}, 32'(tx_s), 32'd1);
  endtask

  initial begin
    logic [19:0] bits;
    logic [19:0] exp_bits;
    int lows;
    reset_n = 1'b0;
    abort   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    data_a  = 16'hA53C;
    data_b  = 16'hA53C;
    data_c  = '0;
    exp_bits = 20'b1101001010_1001111000;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_tx", 32'(tx_s), 32'd1);
      chk("rst_busy", 32'(busy_s), 32'd0);
      chk("rst_done", 32'(done_s), 32'd0);
      chk("rst_bsent", 32'(bsent_s), 32'd0);
    end
    sel = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", 32'(busy_s), 32'd0);
    chk("idle_abort_tx", 32'(tx_s), 32'd1);

    kick(0, 1'b0);
    bits = '0;
    repeat (DIV / 2 - 1) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      bits[k] = tx_s;
      if (k == 9) chk("bs_in_stop0", 32'(bsent_s), 32'd0);
      if (k == 10) chk("bs_after0", 32'(bsent_s), 32'd1);
      if (k < 19) repeat (DIV) @(negedge clk);
    end
    chk("bits_a", 32'(bits), 32'(exp_bits));
    wait_end("pkt_a", 2 * 10 * DIV, 1'b1, 2);
    chk("q_a", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);

    sel = 1;
    kick(1, 1'b1);
    wait_end("pkt_b", 2 * 10 * DIV, 1'b1, 2);
    chk("q_b", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);

    sel = 0;
    kick(0, 1'b0);
    repeat (115) @(negedge clk);
    chk("ab_pre_tx", 32'(tx_s), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    lows = 0;
    for (int i = 0; i < DIV; i++) begin
      if (!tx_s) lows++;
      if (!busy_s) lows++;
      @(negedge clk);
    end
    chk("ab_stop_high", 32'(lows), 32'd0);
    wait_end("ab", 124, 1'b0, 1);
    chk("ab_q", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    repeat (5) @(negedge clk);

    kick(0, 1'b0);
    repeat (40) @(negedge clk);
    data_a  = 16'h1234;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_end("nq", 2 * 10 * DIV, 1'b1, 2);
    chk("q_nq", 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clk);
    chk("no_second", 32'(busy_s), 32'd0);

    data_a = 16'h5AC3;
    kick(0, 1'b0);
    repeat (29) @(negedge clk);
    chk("pre_rst_tx", 32'(tx_s), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx_s), 32'd1);
    chk("mid_rst_busy", 32'(busy_s), 32'd0);
    chk("mid_rst_bsent", 32'(bsent_s), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_q", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    repeat (3) @(negedge clk);
    data_a = 16'hC35A;
    kick(0, 1'b0);
    wait_end("post_rst", 2 * 10 * DIV, 1'b1, 2);
    chk("q_post", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);

    sel = 2;
    for (int i = 0; i < 21; i++)
      data_c[i*32 +: 32] = $urandom;
    kick(2, 1'b0);
    wait_end("pkt_c", 84 * 11 * DIV, 1'b1, 84);
    chk("q_c", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
